// File: rtl/sc_io_ctrl.sv
// sc_io_ctrl: memory-mapped I/O block for a single-cycle CPU.
// Word map (addr[7]=1 selects I/O, idx = addr[6:2]):
//   0..N_OUT-1   output registers (read/write)
//   8..8+N_IN-1  synchronised inputs (read-only)
//   16           CHG status, sticky change flags (read-only)
//   17           CHG clear, write-1-to-clear (reads 0)
//   18           IRQ mask (only when SC_IO_IRQ_EN is defined)
// Optional feature macro: SC_IO_IRQ_EN adds the mask register and the irq flop;
// without it irq is tied low and idx 18 reads 0 / ignores writes.
module sc_io_ctrl #(
  parameter int DATA_W = 32,
  parameter int N_OUT  = 3,
  parameter int N_IN   = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [31:0]              addr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     we,
  input  logic [N_IN*DATA_W-1:0]   in_ports,
  output logic [N_OUT*DATA_W-1:0]  out_ports,
  output logic [DATA_W-1:0]        rdata,
  output logic                     io_sel,
  output logic                     irq
);

  localparam int IDX_IN   = 8;
  localparam int IDX_CHG  = 16;
  localparam int IDX_CLR  = 17;
  localparam int IDX_MASK = 18;

  logic [4:0]               idx;
  logic                     wr_en;
  logic [31:0]              wdata_ext;
  logic [DATA_W-1:0]        out_regs [N_OUT];
  logic [N_IN*DATA_W-1:0]   s1;
  logic [N_IN*DATA_W-1:0]   s2;
  logic [N_IN*DATA_W-1:0]   s3;
  logic [2:0]               live;
  logic [N_IN-1:0]          chg;
  logic [N_IN-1:0]          chg_set;
  logic [N_IN-1:0]          chg_clr;
  logic                     unused_bits;

  assign io_sel    = addr[7];
  assign idx       = addr[6:2];
  assign wr_en     = we & addr[7];
  // Zero-extended store data so the N_IN-wide flag fields can always be sliced,
  // even when DATA_W is narrower than N_IN.
  assign wdata_ext = 32'(wdata);
  assign unused_bits = ^{addr[31:8], addr[1:0], wdata_ext};

  // Output port registers: written by stores that hit their word index.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < N_OUT; k++) out_regs[k] <= '0;
    end else begin
      for (int k = 0; k < N_OUT; k++) begin
        if (wr_en && (int'(idx) == k)) out_regs[k] <= wdata;
        else                           out_regs[k] <= out_regs[k];
      end
    end
  end

  // Flatten the output registers onto the port bus.
  always_comb begin
    out_ports = '0;
    for (int k = 0; k < N_OUT; k++) out_ports[k*DATA_W +: DATA_W] = out_regs[k];
  end

  // Two-flop synchroniser, previous-sample register, and a warm-up shift that
  // marks when s3 holds a genuine post-reset sample.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1   <= '0;
      s2   <= '0;
      s3   <= '0;
      live <= 3'b000;
    end else begin
      s1   <= in_ports;
      s2   <= s1;
      s3   <= s2;
      live <= {live[1:0], 1'b1};
    end
  end

  // Change detect per port, suppressed until both compared samples are real
  // so the reset-to-live transition never raises a flag; plus W1C decode.
  always_comb begin
    chg_set = '0;
    for (int k = 0; k < N_IN; k++) begin
      chg_set[k] = live[2] && (s2[k*DATA_W +: DATA_W] != s3[k*DATA_W +: DATA_W]);
    end
    if (wr_en && (int'(idx) == IDX_CLR)) chg_clr = wdata_ext[N_IN-1:0];
    else                                 chg_clr = '0;
  end

  // Sticky change flags; a set in the same cycle as a clear wins.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) chg <= '0;
    else       chg <= (chg & ~chg_clr) | chg_set;
  end

`ifdef SC_IO_IRQ_EN
  logic [N_IN-1:0] mask;

  // Interrupt mask register and registered interrupt request.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mask <= '0;
      irq  <= 1'b0;
    end else begin
      if (wr_en && (int'(idx) == IDX_MASK)) mask <= wdata_ext[N_IN-1:0];
      else                                  mask <= mask;
      irq <= |(chg & mask);
    end
  end
`else
  assign irq = 1'b0;
`endif

  // Combinational read mux for the addressed I/O word; zero outside I/O space.
  always_comb begin
    rdata = '0;
    if (io_sel) begin
      for (int k = 0; k < N_OUT; k++) begin
        if (int'(idx) == k) rdata = out_regs[k];
      end
      for (int k = 0; k < N_IN; k++) begin
        if (int'(idx) == IDX_IN + k) rdata = s2[k*DATA_W +: DATA_W];
      end
      if (int'(idx) == IDX_CHG) rdata = DATA_W'(chg);
`ifdef SC_IO_IRQ_EN
      if (int'(idx) == IDX_MASK) rdata = DATA_W'(mask);
`endif
    end else begin
      rdata = '0;
    end
  end

endmodule
